wheel_speed_meter: RTL



---
 rtl/wheel_speed_meter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wheel_speed_meter.sv
// Wheel-encoder front end: synchronizes and debounces the tick pin, counts rising
// edges over a fixed gate window and publishes a saturated 8-bit speed plus a stall flag.
module wheel_speed_meter #(
    parameter int GATE_CYCLES     = 1000,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STALL_WINDOWS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wheel_tick,
    output logic [7:0] wheel_speed,
    output logic       speed_valid,
    output logic       wheel_stalled
);

    localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ZERO_W = $clog2(STALL_WINDOWS + 1);
    localparam int EDGE_W = 10;

    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ZERO_W-1:0] ZERO_MAX   = ZERO_W'(STALL_WINDOWS);
    localparam logic [ZERO_W-1:0] ZERO_ALARM = ZERO_W'(STALL_WINDOWS - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    function automatic logic [EDGE_W-1:0] edge_sat_inc(input logic [EDGE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat8(input logic [EDGE_W:0] v);
        return (v > (EDGE_W + 1)'(255)) ? 8'hFF : v[7:0];
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   deb_level_q, deb_level_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    state_t                 state_q, state_d;
    logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [EDGE_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [ZERO_W-1:0]      zero_cnt_q, zero_cnt_d;
    logic [7:0]             speed_q, speed_d;
    logic                   valid_q, valid_d;
    logic                   stalled_q, stalled_d;

    logic                   tick_s;
    logic                   tick_edge;
    logic [EDGE_W:0]        window_total;

    assign tick_s = sync_q[SYNC_STAGES-1];

    // Synchronizer and debouncer run regardless of the measurement state.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], wheel_tick};
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        tick_edge   = 1'b0;
        if (tick_s != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = tick_s;
                tick_edge   = tick_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // An edge on the terminal cycle is folded into the closing window's total.
    assign window_total = {1'b0, edge_cnt_q} + (EDGE_W + 1)'(tick_edge);

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        zero_cnt_d = zero_cnt_q;
        speed_d    = speed_q;
        valid_d    = 1'b0;
        stalled_d  = stalled_q;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (enable) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    speed_d    = sat8(window_total);
                    valid_d    = 1'b1;
                    if (window_total == '0) begin
                        if (zero_cnt_q != ZERO_MAX) begin
                            zero_cnt_d = zero_cnt_q + 1'b1;
                        end
                        stalled_d = (zero_cnt_q >= ZERO_ALARM);
                    end else begin
                        zero_cnt_d = '0;
                        stalled_d  = 1'b0;
                    end
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                    if (tick_edge) begin
                        edge_cnt_d = edge_sat_inc(edge_cnt_q);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            zero_cnt_q  <= '0;
            speed_q     <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            zero_cnt_q  <= zero_cnt_d;
            speed_q     <= speed_d;
            valid_q     <= valid_d;
            stalled_q   <= stalled_d;
        end
    end

    assign wheel_speed   = speed_q;
    assign speed_valid   = valid_q;
    assign wheel_stalled = stalled_q;

endmodule
